traffic_demand_eval: RTL
========================

# traffic_demand_eval

Windowed, parametrised lane-demand evaluator for the smart traffic-light controller. It accumulates per-lane vehicle/pedestrian counts over a configurable sample window and evaluates the demand comparisons on the window sums. Each resulting flag passes through a persistence filter before reaching the phase-control FSM. The filter suppresses phase thrash caused by single noisy samples.

## Interface
- CNT_W, 3: width of each per-sample lane count
- ACC_W, 6: width of each window accumulator (saturating)
- WIN_LEN, 8: accepted samples per evaluation window (≥1)
- PERSIST, 2: consecutive disagreeing windows required before a flag output changes (≥1; 1 = immediate)
- HEAVY_TH, 16: main-lane window sum at or above which main traffic counts as heavy
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- sample_vld  input  1  sample present on count inputs
- sample_rdy  output  1  block accepts a sample this cycle
- clear  input  1  flush the current partial window
- main_num / left_num / sec_num / p_num  input  CNT_W each  per-sample counts
- m_more / l_zero / s_more / p_more  output  1 each  filtered demand flags
- absolute_num  output  3  {main_heavy, s_more, l_zero}, all filtered
- result_vld  output  1  one-cycle pulse per completed evaluation

## Operation
- FSM states: ACCUM and EVAL. Reset state is ACCUM with the sample counter at 0.
- sample_rdy = rst_n & (state==ACCUM) & ~clear.
- A sample is accepted on a clock edge where sample_vld & sample_rdy. On acceptance, each accumulator adds its count, saturating at 2^ACC_W−1, and the sample counter increments.
- The WIN_LEN-th accepted sample moves the FSM to EVAL.
- EVAL lasts exactly one cycle and evaluates the raw flags on the sums:
  - m_more = main > 2·left, computed at ACC_W+1 bits
  - l_zero = left==0
  - s_more = sec ≥ main
  - p_more = p > main+sec, computed at ACC_W+1 bits
  - main_heavy = main ≥ HEAVY_TH
- At the end of EVAL:
  - every raw flag enters its persistence filter
  - accumulators and the sample counter clear
  - result_vld registers 1
  - the FSM returns to ACCUM
- Persistence filter, per flag:
  - raw==out → cnt←0
  - raw≠out and cnt+1==PERSIST → out←raw, cnt←0
  - otherwise → cnt←cnt+1
- clear in ACCUM zeroes the accumulators and the sample counter. It has priority over a simultaneous sample, which is not accepted because sample_rdy is low.
- clear is ignored in EVAL.
- Filtered flags and persistence counters are never touched by clear.
- Reset values: all flags, absolute_num, result_vld, persistence counters, accumulators and the sample counter are 0; state is ACCUM. sample_rdy is 0 while rst_n is low.
- Reset asserted mid-window or during EVAL discards everything; no result_vld is produced.

## Timing
- Window-closing sample accepted at edge k → EVAL during cycle k..k+1 → updated flags and result_vld=1 visible after edge k+1, i.e. 2 edges of latency.
- result_vld is high for exactly one cycle; it is 0 at all other times.
- sample_rdy is low for exactly the EVAL cycle. Back-to-back windows therefore cost WIN_LEN+1 cycles each.
- Flag outputs are registered and change only on the edge that ends EVAL.

## Configuration
- PED_EVAL_EN defined: the p accumulator and the p_more comparison/filter are built.
- PED_EVAL_EN undefined: p_num is ignored, no p accumulator exists, and p_more is tied to 0. All other behaviour is identical.

## Structure
- traffic_pkg holds:
  - the FSM state enum (ACCUM, EVAL)
  - flag index constants (M_MORE, L_ZERO, S_MORE, P_MORE, MAIN_HEAVY)
  - the absolute_num bit positions (2 = heavy, 1 = s_more, 0 = l_zero)
- Sub-module flag_persist is parametrised by PERSIST. It takes raw and an eval strobe, outputs the filtered flag, and holds its own counter. One instance is built per flag: five instances, or four without PED_EVAL_EN.

## Test plan
- Reset: rst_n low 3 cycles → sample_rdy=0, all flags/absolute_num/result_vld=0. After release, sample_rdy=1 with no sample accepted.
- Two windows, each of 8 samples main=5,left=1,sec=5,p=0. Sums are 40/8/40/0.
  - Window 1: result_vld pulses and flags stay 0 (PERSIST=2).
  - Window 2: m_more=1, s_more=1, l_zero=0, absolute_num=3'b110.
- p_num=7, main=1, sec=1 for two windows (sums 56 vs 16) → p_more=1 after window 2 with PED_EVAL_EN; p_more stays 0 without it.
- 3 samples, then clear together with sample_vld, then 8 samples of left=0 → the clear-cycle sample is not accepted. result_vld arrives 2 edges after the 8th post-clear sample; sums exclude pre-clear samples.
- ACC_W=5, WIN_LEN=8, main=7 → main sum saturates at 31, not wrapped 24. main_heavy raw=1 (31≥16).
- sample_vld held high continuously → sample_rdy low for exactly one cycle per 9 cycles. The sample in the EVAL cycle is held and accepted the next cycle; no sample is lost or double-counted.

Source files
------------

// File: rtl/traffic_demand_eval_pkg.sv
// Shared types and constants for the lane-demand evaluator.
// Optional pedestrian evaluation is enabled by defining PED_EVAL_EN.
package traffic_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EVAL  = 1'b1
  } state_e;

  // Flag indices into the raw/filtered flag vectors
  localparam int M_MORE     = 0;
  localparam int L_ZERO     = 1;
  localparam int S_MORE     = 2;
  localparam int P_MORE     = 3;
  localparam int MAIN_HEAVY = 4;
  localparam int NUM_FLAGS  = 5;

  // absolute_num bit positions
  localparam int ABS_HEAVY  = 2;
  localparam int ABS_S_MORE = 1;
  localparam int ABS_L_ZERO = 0;

  // Accumulator lanes; the pedestrian lane only exists with PED_EVAL_EN
  localparam int LANE_MAIN = 0;
  localparam int LANE_LEFT = 1;
  localparam int LANE_SEC  = 2;
  localparam int LANE_P    = 3;
`ifdef PED_EVAL_EN
  localparam int NUM_LANES = 4;
  localparam bit PED_BUILT = 1'b1;
`else
  localparam int NUM_LANES = 3;
  localparam bit PED_BUILT = 1'b0;
`endif

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/traffic_demand_eval_if.sv
// Sample/flag bundle between a count source (master) and the evaluator (slave).
interface traffic_demand_eval_if #(
  parameter int CNT_W = 3
);
  logic             sample_vld;
  logic             sample_rdy;
  logic             clear;
  logic [CNT_W-1:0] main_num;
  logic [CNT_W-1:0] left_num;
  logic [CNT_W-1:0] sec_num;
  logic [CNT_W-1:0] p_num;
  logic             m_more;
  logic             l_zero;
  logic             s_more;
  logic             p_more;
  logic [2:0]       absolute_num;
  logic             result_vld;

  modport master (
    output sample_vld, clear, main_num, left_num, sec_num, p_num,
    input  sample_rdy, m_more, l_zero, s_more, p_more, absolute_num, result_vld
  );

  modport slave (
    input  sample_vld, clear, main_num, left_num, sec_num, p_num,
    output sample_rdy, m_more, l_zero, s_more, p_more, absolute_num, result_vld
  );
endinterface

// File: rtl/traffic_demand_eval_flag_persist.sv
// Persistence filter: the output only follows the raw flag after PERSIST
// consecutive disagreeing evaluations.
module flag_persist
  import traffic_pkg::*;
#(
  parameter int PERSIST = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic eval_i,
  input  logic raw_i,
  output logic flag_o
);
  localparam int PW = cnt_width(PERSIST);
  localparam logic [PW:0] PERSIST_W = (PW+1)'(PERSIST);

  logic [PW-1:0] cnt_q;
  logic          flag_q;
  logic          hit_limit;

  assign hit_limit = (({1'b0, cnt_q} + (PW+1)'(1)) == PERSIST_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else if (eval_i) begin
      if (raw_i == flag_q) begin
        cnt_q <= '0;
      end else if (hit_limit) begin
        flag_q <= raw_i;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + PW'(1);
      end
    end
  end

  assign flag_o = flag_q;
endmodule

// File: rtl/traffic_demand_eval.sv
// Windowed lane-demand evaluator: saturating per-lane window sums, demand
// comparisons, and persistence filtering. PED_EVAL_EN adds the pedestrian lane.
module traffic_demand_eval
  import traffic_pkg::*;
#(
  parameter int CNT_W    = 3,
  parameter int ACC_W    = 6,
  parameter int WIN_LEN  = 8,
  parameter int PERSIST  = 2,
  parameter int HEAVY_TH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_demand_eval_if.slave bus
);
  localparam int                SW       = cnt_width(WIN_LEN);
  localparam logic [SW-1:0]     LAST     = SW'(WIN_LEN - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = '1;
  localparam logic [31:0]       HEAVY_W  = 32'(HEAVY_TH);

  state_e        state_q;
  logic [SW-1:0] smp_cnt_q;
  logic          result_vld_q;

  logic sample_rdy;
  logic accept;
  logic clr_acc;
  logic eval_stb;

  assign sample_rdy = rst_n & (state_q == ACCUM) & ~bus.clear;
  assign accept     = bus.sample_vld & sample_rdy;
  assign eval_stb   = (state_q == EVAL);
  // Sums are consumed during EVAL and dropped on the edge that ends it
  assign clr_acc    = eval_stb | ((state_q == ACCUM) & bus.clear);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      smp_cnt_q    <= '0;
      result_vld_q <= 1'b0;
    end else begin
      result_vld_q <= 1'b0;
      unique case (state_q)
        ACCUM: begin
          if (bus.clear) begin
            smp_cnt_q <= '0;
          end else if (accept) begin
            smp_cnt_q <= smp_cnt_q + SW'(1);
            if (smp_cnt_q == LAST) state_q <= EVAL;
          end
        end
        EVAL: begin
          state_q      <= ACCUM;
          smp_cnt_q    <= '0;
          result_vld_q <= 1'b1;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  logic [NUM_LANES-1:0][CNT_W-1:0] lane_num;
  logic [NUM_LANES-1:0][ACC_W-1:0] lane_sum;

  assign lane_num[LANE_MAIN] = bus.main_num;
  assign lane_num[LANE_LEFT] = bus.left_num;
  assign lane_num[LANE_SEC]  = bus.sec_num;
`ifdef PED_EVAL_EN
  assign lane_num[LANE_P]    = bus.p_num;
`else
  logic unused_p_num;
  assign unused_p_num = ^bus.p_num;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [ACC_W-1:0] acc_q;
      logic [ACC_W-1:0] acc_d;
      logic [ACC_W:0]   sum_wide;

      assign sum_wide = {1'b0, acc_q} + (ACC_W+1)'(lane_num[gi]);

      always_comb begin
        acc_d = acc_q;
        if (clr_acc) begin
          acc_d = '0;
        end else if (accept) begin
          acc_d = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
      end

      assign lane_sum[gi] = acc_q;
    end
  endgenerate

  logic [ACC_W-1:0]     main_s, left_s, sec_s;
  logic [NUM_FLAGS-1:0] raw;
  logic [NUM_FLAGS-1:0] filt;

  assign main_s = lane_sum[LANE_MAIN];
  assign left_s = lane_sum[LANE_LEFT];
  assign sec_s  = lane_sum[LANE_SEC];

  // One extra bit keeps 2*left and main+sec from wrapping
  assign raw[M_MORE]     = {1'b0, main_s} > {left_s, 1'b0};
  assign raw[L_ZERO]     = (left_s == '0);
  assign raw[S_MORE]     = (sec_s >= main_s);
  assign raw[MAIN_HEAVY] = (32'(main_s) >= HEAVY_W);
`ifdef PED_EVAL_EN
  assign raw[P_MORE] = {1'b0, lane_sum[LANE_P]} > ({1'b0, main_s} + {1'b0, sec_s});
`else
  assign raw[P_MORE] = 1'b0;
  logic unused_raw_p;
  assign unused_raw_p = raw[P_MORE];
`endif

  generate
    for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
      if ((gi != P_MORE) || PED_BUILT) begin : g_filt
        flag_persist #(
          .PERSIST (PERSIST)
        ) u_persist (
          .clk    (clk),
          .rst_n  (rst_n),
          .eval_i (eval_stb),
          .raw_i  (raw[gi]),
          .flag_o (filt[gi])
        );
      end else begin : g_tie
        assign filt[gi] = 1'b0;
      end
    end
  endgenerate

  assign bus.sample_rdy              = sample_rdy;
  assign bus.result_vld              = result_vld_q;
  assign bus.m_more                  = filt[M_MORE];
  assign bus.l_zero                  = filt[L_ZERO];
  assign bus.s_more                  = filt[S_MORE];
  assign bus.p_more                  = filt[P_MORE];
  assign bus.absolute_num[ABS_HEAVY]  = filt[MAIN_HEAVY];
  assign bus.absolute_num[ABS_S_MORE] = filt[S_MORE];
  assign bus.absolute_num[ABS_L_ZERO] = filt[L_ZERO];
endmodule
